student_alu_core: RTL and testbench

//   16-bit Hack-style ALU: six control bits select one of 18 canonical functions of x,y.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_operand_pre.sv | 16 +
 rtl/student_alu_core.sv | 109 ++++++++++
 tb/tb_student_alu_core.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types and constants: data width, 6-bit control code and the 18 canonical codes.
// Control code bit order is {zx, nx, zy, ny, f, no}.
package alu_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned CTRL_W = 6;

    typedef logic [CTRL_W-1:0] alu_ctrl_t;

    // Decoded view of a control code, same bit order as the packed code
    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_s;

    localparam alu_ctrl_t C_ZERO    = 6'b101010;
    localparam alu_ctrl_t C_ONE     = 6'b111111;
    localparam alu_ctrl_t C_NEG1    = 6'b111010;
    localparam alu_ctrl_t C_X       = 6'b001100;
    localparam alu_ctrl_t C_Y       = 6'b110000;
    localparam alu_ctrl_t C_NOTX    = 6'b001101;
    localparam alu_ctrl_t C_NOTY    = 6'b110001;
    localparam alu_ctrl_t C_NEGX    = 6'b001111;
    localparam alu_ctrl_t C_NEGY    = 6'b110011;
    localparam alu_ctrl_t C_XPLUS1  = 6'b011111;
    localparam alu_ctrl_t C_YPLUS1  = 6'b110111;
    localparam alu_ctrl_t C_XMINUS1 = 6'b001110;
    localparam alu_ctrl_t C_YMINUS1 = 6'b110010;
    localparam alu_ctrl_t C_XPLUSY  = 6'b000010;
    localparam alu_ctrl_t C_XMINUSY = 6'b010011;
    localparam alu_ctrl_t C_YMINUSX = 6'b000111;
    localparam alu_ctrl_t C_XANDY   = 6'b000000;
    localparam alu_ctrl_t C_XORY    = 6'b010101;

    function automatic alu_ctrl_s alu_decode(input alu_ctrl_t code);
        return alu_ctrl_s'(code);
    endfunction

endpackage

// File: rtl/alu_operand_pre.sv
// Operand preconditioning stage: optional zeroing followed by optional bitwise negation.
module alu_operand_pre #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_zero,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_zeroed;

    assign w_zeroed = i_zero ? '0 : i_data;
    assign o_data   = i_neg ? ~w_zeroed : w_zeroed;

endmodule

// File: rtl/student_alu_core.sv
// Hack-style 16-bit ALU with combinational result/flags and a registered shadow copy.
// Optional signed-overflow flag (ov/ov_r) when ALU_OVF_EN is defined.
module student_alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic [WIDTH-1:0] out_r,
    output logic             zr_r,
    output logic             ng_r
`ifdef ALU_OVF_EN
    ,
    output logic             ov,
    output logic             ov_r
`endif
);

    alu_ctrl_s        w_ctrl;
    logic [WIDTH-1:0] w_xb;
    logic [WIDTH-1:0] w_yb;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_fo;
    logic [WIDTH-1:0] w_out;
    logic             w_zr;
    logic             w_ng;

    logic [WIDTH-1:0] r_out;
    logic             r_zr;
    logic             r_ng;

    assign w_ctrl = alu_decode({zx, nx, zy, ny, f, no});

    alu_operand_pre #(.WIDTH(WIDTH)) u_pre_x (
        .i_data (x),
        .i_zero (w_ctrl.zx),
        .i_neg  (w_ctrl.nx),
        .o_data (w_xb)
    );

    alu_operand_pre #(.WIDTH(WIDTH)) u_pre_y (
        .i_data (y),
        .i_zero (w_ctrl.zy),
        .i_neg  (w_ctrl.ny),
        .o_data (w_yb)
    );

    // Carry out of the adder is intentionally discarded
    assign w_sum = WIDTH'(w_xb + w_yb);
    assign w_and = w_xb & w_yb;
    assign w_fo  = w_ctrl.f ? w_sum : w_and;
    assign w_out = w_ctrl.no ? ~w_fo : w_fo;
    assign w_zr  = ~|w_out;
    assign w_ng  = w_out[WIDTH-1];

    assign out = w_out;
    assign zr  = w_zr;
    assign ng  = w_ng;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= '0;
            r_zr  <= 1'b1;
            r_ng  <= 1'b0;
        end else begin
            r_out <= w_out;
            r_zr  <= w_zr;
            r_ng  <= w_ng;
        end
    end

    assign out_r = r_out;
    assign zr_r  = r_zr;
    assign ng_r  = r_ng;

`ifdef ALU_OVF_EN
    logic w_ov;
    logic r_ov;

    // Signed add overflow, taken before the output negation
    assign w_ov = w_ctrl.f & (w_xb[WIDTH-1] == w_yb[WIDTH-1])
                & (w_fo[WIDTH-1] != w_xb[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ov <= 1'b0;
        end else begin
            r_ov <= w_ov;
        end
    end

    assign ov   = w_ov;
    assign ov_r = r_ov;
`endif

endmodule

// File: tb/tb_student_alu_core.sv
// Self-checking bench for student_alu_core: semantic reference model plus directed literal vectors.
module tb_student_alu_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] x   = 16'h0000;
    logic [15:0] y   = 16'h0000;
    logic [5:0]  code = 6'b101010;

    logic [15:0] out;
    logic        zr;
    logic        ng;
    logic [15:0] out_r;
    logic        zr_r;
    logic        ng_r;
`ifdef ALU_OVF_EN
    logic        ov;
    logic        ov_r;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] exp_out_r = 16'h0000;
    logic        exp_ov_r  = 1'b0;
    logic        reg_known = 1'b0;

    student_alu_core dut (
        .clk   (clk),
        .rst   (rst),
        .x     (x),
        .y     (y),
        .zx    (code[5]),
        .nx    (code[4]),
        .zy    (code[3]),
        .ny    (code[2]),
        .f     (code[1]),
        .no    (code[0]),
        .out   (out),
        .zr    (zr),
        .ng    (ng),
        .out_r (out_r),
        .zr_r  (zr_r),
        .ng_r  (ng_r)
`ifdef ALU_OVF_EN
        ,
        .ov    (ov),
        .ov_r  (ov_r)
`endif
    );

    always #5 clk = ~clk;

    // Canonical codes are modelled by their arithmetic meaning; others by the bit-level formula
    function automatic logic [15:0] ref_out(input logic [5:0] c, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] xa, xb, ya, yb, fo;
        case (c)
            6'b101010: return 16'h0000;
            6'b111111: return 16'h0001;
            6'b111010: return 16'hFFFF;
            6'b001100: return a;
            6'b110000: return b;
            6'b001101: return ~a;
            6'b110001: return ~b;
            6'b001111: return 16'h0000 - a;
            6'b110011: return 16'h0000 - b;
            6'b011111: return a + 16'h0001;
            6'b110111: return b + 16'h0001;
            6'b001110: return a - 16'h0001;
            6'b110010: return b - 16'h0001;
            6'b000010: return a + b;
            6'b010011: return a - b;
            6'b000111: return b - a;
            6'b000000: return a & b;
            6'b010101: return a | b;
            default: begin
                xa = c[5] ? 16'h0000 : a;
                xb = c[4] ? ~xa : xa;
                ya = c[3] ? 16'h0000 : b;
                yb = c[2] ? ~ya : ya;
                fo = c[1] ? xb + yb : xb & yb;
                return c[0] ? ~fo : fo;
            end
        endcase
    endfunction

    // Signed overflow of the pre-negation sum, from sign-extended integer addition
    function automatic logic ref_ov(input logic [5:0] c, input logic [15:0] a, input logic [15:0] b);
        int sa, sb, s;
        logic [15:0] xb, yb;
        xb = c[4] ? ~(c[5] ? 16'h0000 : a) : (c[5] ? 16'h0000 : a);
        yb = c[2] ? ~(c[3] ? 16'h0000 : b) : (c[3] ? 16'h0000 : b);
        sa = int'($signed(xb));
        sb = int'($signed(yb));
        s  = sa + sb;
        return c[1] && (s > 32767 || s < -32768);
    endfunction

    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (code=%b x=%h y=%h t=%0t)", name, act, exp, code, x, y, $time);
    endfunction

    // Expected registered state, captured at the same edge the DUT captures
    always @(posedge clk) begin
        if (rst) begin
            exp_out_r = 16'h0000;
            exp_ov_r  = 1'b0;
        end else begin
            exp_out_r = ref_out(code, x, y);
            exp_ov_r  = ref_ov(code, x, y);
        end
        reg_known = 1'b1;
    end

    always @(negedge clk) begin
        logic [15:0] e;
        e = ref_out(code, x, y);
        check("cmp_out", out, e);
        check("cmp_zr", 16'(zr), 16'(e == 16'h0000));
        check("cmp_ng", 16'(ng), 16'(e[15]));
`ifdef ALU_OVF_EN
        check("cmp_ov", 16'(ov), 16'(ref_ov(code, x, y)));
`endif
        if (reg_known) begin
            check("cmp_out_r", out_r, exp_out_r);
            check("cmp_zr_r", 16'(zr_r), 16'(exp_out_r == 16'h0000));
            check("cmp_ng_r", 16'(ng_r), 16'(exp_out_r[15]));
`ifdef ALU_OVF_EN
            check("cmp_ov_r", 16'(ov_r), 16'(exp_ov_r));
`endif
        end
    end

    task automatic vec(input logic [5:0] c, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] e, input logic ezr, input logic eng);
        @(posedge clk);
        #2;
        code = c;
        x    = a;
        y    = b;
        #1;
        check("vec_out", out, e);
        check("vec_zr", 16'(zr), 16'(ezr));
        check("vec_ng", 16'(ng), 16'(eng));
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_r", out_r, 16'h0000);
        check("rst_zr_r", 16'(zr_r), 16'h0001);
        check("rst_ng_r", 16'(ng_r), 16'h0000);
        rst = 1'b0;

        vec(6'b101010, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        vec(6'b111111, 16'h0000, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        vec(6'b111010, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        vec(6'b110010, 16'h0000, 16'hFFFF, 16'hFFFE, 1'b0, 1'b1);
        vec(6'b010011, 16'h0000, 16'hFFFF, 16'h0001, 1'b0, 1'b0);

        vec(6'b000010, 16'h0011, 16'h0003, 16'h0014, 1'b0, 1'b0);
        vec(6'b010011, 16'h0011, 16'h0003, 16'h000E, 1'b0, 1'b0);
        vec(6'b000111, 16'h0011, 16'h0003, 16'hFFF2, 1'b0, 1'b1);
        vec(6'b000000, 16'h0011, 16'h0003, 16'h0001, 1'b0, 1'b0);
        vec(6'b010101, 16'h0011, 16'h0003, 16'h0013, 1'b0, 1'b0);
        vec(6'b001111, 16'h0011, 16'h0003, 16'hFFEF, 1'b0, 1'b1);
        vec(6'b001110, 16'h0011, 16'h0003, 16'h0010, 1'b0, 1'b0);
        vec(6'b110111, 16'h0011, 16'h0003, 16'h0004, 1'b0, 1'b0);
        vec(6'b110001, 16'h0011, 16'h0003, 16'hFFFC, 1'b0, 1'b1);
        vec(6'b001101, 16'h0011, 16'h0003, 16'hFFEE, 1'b0, 1'b1);

        // Mid-op reset: output keeps tracking inputs, registered copy is cleared for one sample
        vec(6'b000010, 16'h0011, 16'h0003, 16'h0014, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        check("pre_rst_out_r", out_r, 16'h0014);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("midrst_out_r", out_r, 16'h0000);
        check("midrst_zr_r", 16'(zr_r), 16'h0001);
        check("midrst_ng_r", 16'(ng_r), 16'h0000);
        check("midrst_out", out, 16'h0014);
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("post_rst_out_r", out_r, 16'h0014);

        // Latency: code change between edges is visible immediately on out, one edge later on out_r
        vec(6'b101010, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        check("lat_out_r0", out_r, 16'h0000);
        code = 6'b111010;
        #1;
        check("lat_out", out, 16'hFFFF);
        check("lat_out_r_hold", out_r, 16'h0000);
        @(posedge clk);
        #1;
        check("lat_out_r1", out_r, 16'hFFFF);
        check("lat_ng_r1", 16'(ng_r), 16'h0001);

        // Every control code, legal or not, against the model
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #2;
            code = 6'(i);
            x    = 16'h1234;
            y    = 16'h00F0;
        end
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #2;
            code = 6'(i);
            x    = 16'h8000;
            y    = 16'h7FFF;
        end

`ifdef ALU_OVF_EN
        @(posedge clk);
        #2;
        code = 6'b000010;
        x    = 16'h7FFF;
        y    = 16'h0001;
        #1;
        check("ovf_out", out, 16'h8000);
        check("ovf_ov", 16'(ov), 16'h0001);
        check("ovf_ng", 16'(ng), 16'h0001);
        @(posedge clk);
        #1;
        check("ovf_ov_r", 16'(ov_r), 16'h0001);
        #1;
        x = 16'h0011;
        y = 16'h0003;
        #1;
        check("noovf_ov", 16'(ov), 16'h0000);
`endif

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
